// File: rtl/stream_mux_4to1.sv
// stream_mux_4to1: 4-to-1 valid/ready stream merger with registered output and source index.
// Define RR_ARB_EN for round-robin arbitration; otherwise fixed priority (channel 0 highest).
module stream_mux_4to1 #(
  parameter int W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  input  logic [4*W-1:0]   in_data,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [1:0]       out_sel,
  input  logic             out_ready,
  output logic [CNT_W-1:0] beat_cnt
);
  logic [1:0] last_grant, base, g;
  logic       hit, load_en;
  assign load_en = !out_valid || out_ready;
`ifdef RR_ARB_EN
  assign base = last_grant + 2'd1;
`else
  logic unused_last;
  assign base = 2'd0;
  assign unused_last = ^last_grant;
`endif
  // Scan the search order backwards so the earliest requester is written last and wins.
  always_comb begin
    g = 2'd0;
    hit = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (in_valid[base + 2'(k)]) begin
        g = base + 2'(k);
        hit = 1'b1;
      end
    end
  end
  assign in_ready = (rst || !load_en || !hit) ? 4'b0000 : 4'b0001 << g;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= 2'd0;
      beat_cnt   <= '0;
      last_grant <= 2'd3;
    end else if (|in_ready) begin
      out_valid  <= 1'b1;
      out_data   <= in_data[g*W +: W];
      out_sel    <= g;
      last_grant <= g;
      beat_cnt   <= beat_cnt + CNT_W'(1);
    end else if (load_en) begin
      out_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stream_mux_4to1.sv
// tb_stream_mux_4to1: directed vector table, corner sequences and randomized run against a reference model.
module tb_stream_mux_4to1;
  localparam int W = 8;
  localparam int CNT_W = 4;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       in_valid = 4'b0;
  logic [4*W-1:0]   in_data = '0;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [1:0]       out_sel;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] beat_cnt;
  int tests = 0, fails = 0;
  bit         m_ov;
  logic [W-1:0] m_d;
  int         m_s, m_cnt, m_last;
  logic [3:0] acc_last;
  typedef struct {
    logic        r;
    logic [3:0]  iv;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  os;
    int          cnt;
  } vec_t;
  vec_t tbl[12];

  stream_mux_4to1 #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready),
    .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int m_grant();
    int base;
    if (rst || (m_ov && !out_ready) || in_valid == 4'b0) return -1;
`ifdef RR_ARB_EN
    base = (m_last + 1) % 4;
`else
    base = 0;
`endif
    for (int k = 0; k < 4; k++) if (in_valid[(base + k) % 4]) return (base + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] m_ready();
    int g = m_grant();
    return g < 0 ? 4'b0000 : 4'(1 << g);
  endfunction

  task automatic m_update();
    int g = m_grant();
    if (rst) begin
      m_ov = 0; m_d = '0; m_s = 0; m_cnt = 0; m_last = 3;
    end else if (g >= 0) begin
      m_ov = 1; m_d = in_data[g*W +: W]; m_s = g; m_cnt = (m_cnt + 1) % (1 << CNT_W); m_last = g;
    end else if (!m_ov || out_ready) begin
      m_ov = 0;
    end
  endtask

  task automatic cycle(input string tag);
    @(negedge clk);
    acc_last = m_ready();
    chk({tag, "/in_ready"}, 32'(in_ready), 32'(acc_last));
    m_update();
    @(posedge clk); #1;
    chk({tag, "/out_valid"}, 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      chk({tag, "/out_data"}, 32'(out_data), 32'(m_d));
      chk({tag, "/out_sel"}, 32'(out_sel), 32'(m_s));
    end
    chk({tag, "/beat_cnt"}, 32'(beat_cnt), 32'(m_cnt));
  endtask

  initial begin
    int sel_exp;
    tbl[0]  = '{1, 4'hF, 32'h0, 1, 4'b0000, 0, 8'h00, 2'd0, 0};
    tbl[1]  = '{1, 4'hF, 32'h0, 1, 4'b0000, 0, 8'h00, 2'd0, 0};
    tbl[2]  = '{0, 4'b0100, 32'h00A50000, 1, 4'b0100, 1, 8'hA5, 2'd2, 1};
    tbl[3]  = '{0, 4'b0000, 32'h0, 1, 4'b0000, 0, 8'hA5, 2'd2, 1};
    tbl[4]  = '{0, 4'b0010, 32'h00003C00, 0, 4'b0010, 1, 8'h3C, 2'd1, 2};
    tbl[5]  = '{0, 4'b0010, 32'h00007700, 0, 4'b0000, 1, 8'h3C, 2'd1, 2};
    tbl[6]  = '{0, 4'b0010, 32'h00007700, 0, 4'b0000, 1, 8'h3C, 2'd1, 2};
    tbl[7]  = '{0, 4'b0010, 32'h00007700, 0, 4'b0000, 1, 8'h3C, 2'd1, 2};
    tbl[8]  = '{0, 4'b0010, 32'h00007700, 1, 4'b0010, 1, 8'h77, 2'd1, 3};
    tbl[9]  = '{0, 4'b0000, 32'h0, 1, 4'b0000, 0, 8'h77, 2'd1, 3};
    tbl[10] = '{0, 4'b1000, 32'hE1000000, 0, 4'b1000, 1, 8'hE1, 2'd3, 4};
    tbl[11] = '{1, 4'b1000, 32'hE1000000, 0, 4'b0000, 0, 8'h00, 2'd0, 0};
    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].r; in_valid = tbl[i].iv; in_data = tbl[i].d; out_ready = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d/in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      @(posedge clk); #1;
      chk($sformatf("vec%0d/out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("vec%0d/out_data", i), 32'(out_data), 32'(tbl[i].od));
      chk($sformatf("vec%0d/out_sel", i), 32'(out_sel), 32'(tbl[i].os));
      chk($sformatf("vec%0d/beat_cnt", i), 32'(beat_cnt), 32'(tbl[i].cnt));
    end
    rst = 1; in_valid = 4'h0; out_ready = 1;
    @(posedge clk); #1;
    rst = 0; in_valid = 4'hF; in_data = 32'h44332211;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
`ifdef RR_ARB_EN
      sel_exp = i % 4;
`else
      sel_exp = 0;
`endif
      chk($sformatf("arb%0d/out_sel", i), 32'(out_sel), 32'(sel_exp));
      chk($sformatf("arb%0d/out_data", i), 32'(out_data), 32'(8'h11 * (sel_exp + 1)));
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0; in_valid = 4'b0001; in_data = 32'h000000C7; out_ready = 1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
    end
    chk("wrap/cnt15", 32'(beat_cnt), 32'd15);
    @(posedge clk); #1;
    chk("wrap/cnt0", 32'(beat_cnt), 32'd0);
    chk("wrap/out_valid", 32'(out_valid), 32'd1);
    rst = 1;
    @(posedge clk); #1;
    chk("midrst/out_valid", 32'(out_valid), 32'd0);
    chk("midrst/beat_cnt", 32'(beat_cnt), 32'd0);
    rst = 1; in_valid = 4'h0;
    cycle("rnd_rst");
    rst = 0;
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < 4; c++) begin
        if (!in_valid[c] || acc_last[c]) begin
          in_valid[c] = ($urandom_range(0, 2) != 0);
          in_data[c*W +: W] = W'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 40) == 0);
      cycle($sformatf("rnd%0d", n));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
